fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 Parameter BUF_DEPTH, default 2, instruction buffer entries and maximum credits (outstanding plus buffered).
REQ-003 Ports: clock  in  1  clock; all state updates on posedge.
REQ-004 Ports: reset  in  1  synchronous, active-high.
REQ-005 Ports: ctrl_fetch  in  1  redirect request from the branch unit.
REQ-006 Ports: new_pc  in  32  redirect target, qualified by ctrl_fetch.
REQ-007 Ports: global_reset  in  1  pipeline flush, with no PC change.
REQ-008 Ports: imem_req_valid  out  1; imem_req_addr  out  32; imem_req_ready  in  1.
REQ-009 Ports: imem_rsp_valid  in  1; imem_rsp_data  in  32. Responses are in order and of variable latency, one or more cycles.
REQ-010 Ports: instr_valid  out  1; instr  out  32; instr_pc  out  32; instr_ready  in  1 (decode backpressure).

Function
REQ-011 A request fires on imem_req_valid && imem_req_ready; the PC then advances by 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-012 imem_req_valid = (state == RUN) && !flush && (outstanding + drop_cnt + occupancy < BUF_DEPTH), where flush = ctrl_fetch || global_reset.
REQ-013 Each fired request pushes its address into an in-flight address FIFO of depth BUF_DEPTH; the matching response pairs data with that address.
REQ-014 When drop_cnt == 0, a response is written to the buffer as {data, pc}; buffer space is always guaranteed by REQ-012.
REQ-015 When drop_cnt != 0, a response is discarded and drop_cnt is decremented.
REQ-016 Buffer head drives instr/instr_pc; instr_valid = occupancy != 0; a pop occurs on instr_valid && instr_ready.
REQ-017 Push and pop in the same cycle are legal at any occupancy, including full.
REQ-018 Flush in cycle N:
  - buffer is emptied;
  - drop_cnt <= drop_cnt + outstanding - (1 if a response arrives in N, else 0);
  - the address FIFO is cleared;
  - a response arriving in cycle N is discarded.
REQ-019 ctrl_fetch in cycle N loads PC <= new_pc; the first request carries new_pc no earlier than N+1, as soon as credits allow.
REQ-020 global_reset without ctrl_fetch flushes and keeps the current PC (the next sequential address).
REQ-021 Priority: reset > ctrl_fetch > request increment.
REQ-022 instr_valid is 0 during the flush cycle and the cycle after it, even if a response arrives.
REQ-023 FSM: RUN (normal) and HALT (only with the macro in REQ-029).
  - RUN -> HALT on a misaligned redirect;
  - HALT -> RUN only on reset.
REQ-024 Latency: a response in cycle N is visible on instr the cycle after N.

Reset
REQ-025 Reset values:
  - PC = RESET_PC; state = RUN;
  - occupancy, outstanding and drop_cnt = 0; address FIFO empty;
  - instr_valid = 0, imem_req_valid = 0 during reset;
  - instr and instr_pc = 0.
REQ-026 Responses arriving during reset or after reset for pre-reset requests are not tracked; the memory is reset together with this block.
REQ-027 The first request is asserted in the first cycle after reset deasserts, with addr RESET_PC.
REQ-028 Reset mid-operation discards all buffered and in-flight state in one cycle.

Configuration
REQ-029 Macro FETCH_MISALIGN_TRAP_EN.
  - Defined: adds port misalign  out  1.
  - A ctrl_fetch with new_pc[1:0] != 0 flushes, sets misalign = 1 (sticky) and enters HALT.
  - In HALT no requests are issued, and in-flight responses are dropped.
REQ-030 Macro FETCH_MISALIGN_TRAP_EN undefined: no misalign port and no HALT state; new_pc[1:0] is forced to 0.

Structure
REQ-031 Shared package fetch_pkg holds:
  - the XLEN = 32 constant;
  - the PC_STEP = 4 constant;
  - the fetch_state_t enum {RUN, HALT};
  - the fetch_entry_t struct {instr, pc}.
REQ-032 One sub-module, fetch_fifo (parameterised width and depth, with push, pop, clear, full, empty and count), is instantiated twice: the instruction buffer and the address FIFO.

Verification
REQ-033 Reset, always-ready memory with 1-cycle latency, instr_ready = 1 -> requests at 0x0, 0x4, 0x8, 0xC; instructions emitted in order with matching instr_pc.
REQ-034 instr_ready = 0 for 6 cycles -> at most 2 requests outstanding or buffered, no data lost; 0x0 then 0x4 are delivered on release.
REQ-035 ctrl_fetch = 1 with new_pc = 0x100 while 2 requests are outstanding, latency 3 -> both responses dropped, next request addr 0x100, first instr_pc = 0x100.
REQ-036 global_reset alone with a response arriving in the same cycle -> response dropped, buffer empty, the next request continues from the current PC.
REQ-037 PC preset to 32'hFFFF_FFFC -> the next request addr is 0x0.
REQ-038 FETCH_MISALIGN_TRAP_EN defined, ctrl_fetch with new_pc = 0x102 -> misalign = 1, imem_req_valid stays 0 until reset.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch unit.
package fetch_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned PC_STEP = 4;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush (clear), used for both the instruction
// buffer and the in-flight address queue. Push while full is accepted only
// when a pop happens in the same cycle.
module fetch_fifo #(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; clear drops everything in one cycle.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (do_push && !do_pop)      count <= count + CNT_W'(1);
            else if (do_pop && !do_push) count <= count - CNT_W'(1);
        end
    end

    // Storage array, no reset needed: contents are only read below count.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues in-order memory requests under a credit
// limit, buffers responses for decode, and handles redirect/flush by
// counting in-flight responses that must be discarded.
// Optional macro FETCH_MISALIGN_TRAP_EN adds a misalign output and a HALT
// state entered on a misaligned redirect; without it the low target bits
// are cleared.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned     BUF_DEPTH = 2
) (
    input  logic            clock,
    input  logic            reset,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic            misalign,
`endif
    input  logic            ctrl_fetch,
    input  logic [XLEN-1:0] new_pc,
    input  logic            global_reset,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 2;
    localparam int unsigned ENT_W = $bits(fetch_entry_t);

    fetch_state_t    state_q;
    fetch_state_t    state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_target;
    logic [CNT_W-1:0] drop_cnt_q;
    logic [CNT_W-1:0] drop_cnt_d;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] occupancy;
    logic            flush;
    logic            credit_ok;
    logic            req_fire;
    logic            rsp_tracked;
    logic            rsp_keep;
    logic            buf_pop;
    logic            addr_full;
    logic            addr_empty;
    logic            buf_full;
    logic            buf_empty;
    logic [XLEN-1:0] rsp_pc;
    fetch_entry_t    buf_in;
    fetch_entry_t    buf_head;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign pc_target = new_pc;
`else
    assign pc_target = new_pc & ~XLEN'(3);
`endif

    // Credits cover requests in flight, responses still to be dropped and
    // buffered entries; the FIFO full flags are redundant backstops.
    assign flush     = ctrl_fetch || global_reset;
    assign credit_ok = ((SUM_W'(outstanding) + SUM_W'(drop_cnt_q) + SUM_W'(occupancy))
                        < SUM_W'(BUF_DEPTH)) && !addr_full && !buf_full;

    assign imem_req_valid = !reset && (state_q == RUN) && !flush && credit_ok;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses for pre-reset requests are ignored: nothing to pair them with.
    assign rsp_tracked = imem_rsp_valid && !reset && ((drop_cnt_q != '0) || !addr_empty);
    assign rsp_keep    = rsp_tracked && (drop_cnt_q == '0) && !flush && (state_q == RUN);
    assign buf_in      = '{instr: imem_rsp_data, pc: rsp_pc};

    assign instr_valid = !reset && !flush && !buf_empty;
    assign instr       = buf_empty ? '0 : buf_head.instr;
    assign instr_pc    = buf_empty ? '0 : buf_head.pc;
    assign buf_pop     = instr_valid && instr_ready;

    fetch_fifo #(.WIDTH(XLEN), .DEPTH(BUF_DEPTH)) u_addr_fifo (
        .clock     (clock),
        .reset     (reset),
        .clear     (flush),
        .push      (req_fire),
        .push_data (pc_q),
        .pop       (rsp_keep),
        .pop_data  (rsp_pc),
        .full      (addr_full),
        .empty     (addr_empty),
        .count     (outstanding)
    );

    fetch_fifo #(.WIDTH(ENT_W), .DEPTH(BUF_DEPTH)) u_instr_buf (
        .clock     (clock),
        .reset     (reset),
        .clear     (flush),
        .push      (rsp_keep),
        .push_data (buf_in),
        .pop       (buf_pop),
        .pop_data  (buf_head),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (occupancy)
    );

    // Next state and drop-count: a flush turns every in-flight request into a drop.
    always_comb begin
        state_d    = state_q;
        drop_cnt_d = drop_cnt_q;
        if (flush) begin
            drop_cnt_d = CNT_W'(SUM_W'(drop_cnt_q) + SUM_W'(outstanding) - SUM_W'(rsp_tracked));
        end else if (rsp_tracked && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CNT_W'(1);
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        if ((state_q == RUN) && ctrl_fetch && (pc_target[1:0] != 2'b00)) begin
            state_d = HALT;
        end
`endif
    end

    // State, PC and drop-count registers; redirect beats sequential increment.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            drop_cnt_q <= drop_cnt_d;
            if (ctrl_fetch)    pc_q <= pc_target;
            else if (req_fire) pc_q <= pc_q + XLEN'(PC_STEP);
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    // Sticky trap flag, mirrors HALT which only reset leaves.
    always_ff @(posedge clock) begin
        if (reset) misalign <= 1'b0;
        else       misalign <= (state_d == HALT);
    end
`endif

endmodule
